// File: rtl/bfp16_accumulator.sv
// ---------------------------------------------------------------------------
// bfp16_accumulator
//
// Reduces a stream of BFP16 values (1 sign, 8 exponent bias 127, 7 fraction)
// to one BFP16 sum per stream. Each accepted element is added to the running
// accumulator by a small multi-cycle FSM: IDLE (accept) -> ALIGN -> ADD ->
// NORM, then OUT when the element carried in_last.
//
// Optional feature macro: BFP16_ACC_RNE_EN
//   defined   : NORM rounds to nearest, ties-to-even (guard bits + sticky)
//   undefined : NORM truncates the fraction; no sticky logic is built
//
// Parameters
//   GUARD_BITS  extra LSBs kept below the fraction during align/add (>= 2)
//   CNT_W       width of the per-stream element counter
//
// Ports
//   clk        clock, all logic on posedge
//   rst        synchronous active-high reset, aborts any stream in flight
//   in_valid   in_data/in_last valid
//   in_ready   element can be accepted this cycle (IDLE only)
//   in_data    BFP16 operand
//   in_last    final element of the current stream
//   out_valid  out_data/out_count valid, held until out_ready
//   out_ready  consumer accepts the result
//   out_data   BFP16 stream sum
//   out_count  elements accepted in the stream, saturating
//   busy       FSM not in IDLE
// ---------------------------------------------------------------------------
module bfp16_accumulator #(
    parameter int GUARD_BITS = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             busy
);
    localparam int            MW   = 8 + GUARD_BITS;  // {1, frac, guard}
    localparam logic [15:0]   QNAN = 16'h7FC0;
    localparam logic [MW-1:0] ONES = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_OUT
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      x_q, x_d;
    logic             last_q, last_d;
    logic [MW-1:0]    mag_a_q, mag_a_d;
    logic [MW-1:0]    mag_b_q, mag_b_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic [7:0]       exp_q, exp_d;
    logic             special_q, special_d;
    logic [15:0]      special_val_q, special_val_d;
    logic [MW:0]      sum_q, sum_d;
    logic             sum_sign_q, sum_sign_d;
`ifdef BFP16_ACC_RNE_EN
    logic             sticky_q, sticky_d;
    logic             sticky_n;
    logic             round_up;
    logic [8:0]       mant_r;
`endif

    // Combinational temporaries
    logic [7:0]       ea, eb, diff, lz;
    logic             a_nan, b_nan, a_inf, b_inf;
    logic [MW-1:0]    ma, mb, norm;
    logic signed [9:0] e_n;
    logic [6:0]       frac;
    logic             flush;

    // Leading-zero count of a nonzero mantissa (MSB-first).
    function automatic logic [7:0] lead_zeros(input logic [MW-1:0] v);
        logic [7:0] n;
        n = 8'(MW);
        for (int i = 0; i < MW; i++) begin
            if (v[i]) n = 8'(MW - 1 - i);
        end
        return n;
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        count_d       = count_q;
        x_d           = x_q;
        last_d        = last_q;
        mag_a_d       = mag_a_q;
        mag_b_d       = mag_b_q;
        sign_a_d      = sign_a_q;
        sign_b_d      = sign_b_q;
        exp_d         = exp_q;
        special_d     = special_q;
        special_val_d = special_val_q;
        sum_d         = sum_q;
        sum_sign_d    = sum_sign_q;
`ifdef BFP16_ACC_RNE_EN
        sticky_d      = sticky_q;
        sticky_n      = 1'b0;
        round_up      = 1'b0;
        mant_r        = '0;
`endif
        ea    = acc_q[14:7];
        eb    = x_q[14:7];
        a_nan = (ea == 8'hFF) && (acc_q[6:0] != 7'h0);
        b_nan = (eb == 8'hFF) && (x_q[6:0] != 7'h0);
        a_inf = (ea == 8'hFF) && (acc_q[6:0] == 7'h0);
        b_inf = (eb == 8'hFF) && (x_q[6:0] == 7'h0);
        // Zero exponent flushes the operand to zero regardless of sign.
        ma    = (ea == 8'h00) ? '0 : {1'b1, acc_q[6:0], {GUARD_BITS{1'b0}}};
        mb    = (eb == 8'h00) ? '0 : {1'b1, x_q[6:0], {GUARD_BITS{1'b0}}};
        diff  = '0;
        lz    = '0;
        norm  = '0;
        e_n   = '0;
        frac  = '0;
        flush = 1'b0;

        in_ready  = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        out_valid = (state_q == S_OUT);
        out_data  = (state_q == S_OUT) ? acc_q : 16'h0000;
        out_count = (state_q == S_OUT) ? count_q : '0;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d     = in_data;
                    last_d  = in_last;
                    count_d = (&count_q) ? count_q : count_q + 1'b1;
                    state_d = S_ALIGN;
                end
            end
            S_ALIGN: begin
                // Specials are resolved here and bypass the arithmetic; a NaN
                // accumulator stays NaN for the rest of the stream.
                special_d = 1'b1;
                if (a_nan || b_nan)      special_val_d = QNAN;
                else if (a_inf && b_inf) special_val_d = (acc_q[15] == x_q[15]) ? acc_q : QNAN;
                else if (a_inf)          special_val_d = acc_q;
                else if (b_inf)          special_val_d = x_q;
                else                     special_d     = 1'b0;
                sign_a_d = acc_q[15];
                sign_b_d = x_q[15];
                // Shifts of MW or more clear the smaller operand entirely.
                if (ea >= eb) begin
                    exp_d   = ea;
                    diff    = ea - eb;
                    mag_a_d = ma;
                    mag_b_d = mb >> diff;
`ifdef BFP16_ACC_RNE_EN
                    sticky_d = |(mb & ~(ONES << diff));
`endif
                end else begin
                    exp_d   = eb;
                    diff    = eb - ea;
                    mag_a_d = ma >> diff;
                    mag_b_d = mb;
`ifdef BFP16_ACC_RNE_EN
                    sticky_d = |(ma & ~(ONES << diff));
`endif
                end
                state_d = S_ADD;
            end
            S_ADD: begin
                if (sign_a_q == sign_b_q) begin
                    sum_d      = {1'b0, mag_a_q} + {1'b0, mag_b_q};
                    sum_sign_d = sign_a_q;
                end else if (mag_a_q >= mag_b_q) begin
                    sum_d      = {1'b0, mag_a_q - mag_b_q};
                    sum_sign_d = sign_a_q;
                end else begin
                    sum_d      = {1'b0, mag_b_q - mag_a_q};
                    sum_sign_d = sign_b_q;
                end
                state_d = S_NORM;
            end
            S_NORM: begin
                if (special_q) begin
                    acc_d = special_val_q;
                end else if (sum_q == '0) begin
                    acc_d = 16'h0000;  // exact cancellation is always +0
                end else begin
                    if (sum_q[MW]) begin
                        norm = sum_q[MW:1];
                        e_n  = $signed({2'b00, exp_q}) + 10'sd1;
`ifdef BFP16_ACC_RNE_EN
                        sticky_n = sticky_q | sum_q[0];
`endif
                    end else begin
                        lz   = lead_zeros(sum_q[MW-1:0]);
                        norm = sum_q[MW-1:0] << lz;
                        e_n  = $signed({2'b00, exp_q}) - $signed({2'b00, lz});
`ifdef BFP16_ACC_RNE_EN
                        sticky_n = sticky_q;
`endif
                    end
                    flush = (e_n <= 10'sd0);
                    frac  = 7'(norm >> GUARD_BITS);
`ifdef BFP16_ACC_RNE_EN
                    round_up = norm[GUARD_BITS-1]
                             & ((|norm[GUARD_BITS-2:0]) | sticky_n | frac[0]);
                    mant_r   = {2'b01, frac} + 9'(round_up);
                    if (mant_r[8]) begin
                        frac = 7'h00;
                        e_n  = e_n + 10'sd1;
                    end else begin
                        frac = 7'(mant_r);
                    end
`endif
                    if (flush)                acc_d = 16'h0000;
                    else if (e_n >= 10'sd255) acc_d = {sum_sign_q, 8'hFF, 7'h00};
                    else                      acc_d = {sum_sign_q, e_n[7:0], frac};
                end
                state_d = last_q ? S_OUT : S_IDLE;
            end
            S_OUT: begin
                if (out_ready) begin
                    acc_d   = 16'h0000;
                    count_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    // NOTE: all registers, including the datapath, are reset so an aborted
    // stream leaves no partial state behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            acc_q         <= 16'h0000;
            count_q       <= '0;
            x_q           <= 16'h0000;
            last_q        <= 1'b0;
            mag_a_q       <= '0;
            mag_b_q       <= '0;
            sign_a_q      <= 1'b0;
            sign_b_q      <= 1'b0;
            exp_q         <= 8'h00;
            special_q     <= 1'b0;
            special_val_q <= 16'h0000;
            sum_q         <= '0;
            sum_sign_q    <= 1'b0;
`ifdef BFP16_ACC_RNE_EN
            sticky_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            count_q       <= count_d;
            x_q           <= x_d;
            last_q        <= last_d;
            mag_a_q       <= mag_a_d;
            mag_b_q       <= mag_b_d;
            sign_a_q      <= sign_a_d;
            sign_b_q      <= sign_b_d;
            exp_q         <= exp_d;
            special_q     <= special_d;
            special_val_q <= special_val_d;
            sum_q         <= sum_d;
            sum_sign_q    <= sum_sign_d;
`ifdef BFP16_ACC_RNE_EN
            sticky_q      <= sticky_d;
`endif
        end
    end

endmodule

// File: tb/tb_bfp16_accumulator.sv
// ---------------------------------------------------------------------------
// tb_bfp16_accumulator
//
// Self-checking bench for bfp16_accumulator. Directed streams cover the
// documented examples, backpressure, mid-stream reset and count saturation;
// random streams are compared against a behavioural model of the BFP16
// accumulate rules written with integer arithmetic.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_bfp16_accumulator;
    localparam int          G     = 3;
    localparam int          CNT_W = 4;  // small so saturation is reachable
    localparam int          MW    = 8 + G;
    localparam logic [15:0] QNAN  = 16'h7FC0;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_data;
    logic [CNT_W-1:0] out_count;
    logic             busy;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] stream_q[$];

    bfp16_accumulator #(
        .GUARD_BITS(G),
        .CNT_W     (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_count(out_count),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Reference: acc + b following the BFP16 accumulate rules.
    function automatic logic [15:0] model_add(input logic [15:0] a, input logic [15:0] b);
        int     ea, eb, e, d, frac;
        longint ma, mb, mag, top;
        bit     sa, sb, sign;
`ifdef BFP16_ACC_RNE_EN
        bit     sticky;
        longint rem, half;
        sticky = 1'b0;
`endif
        ea = int'(a[14:7]);
        eb = int'(b[14:7]);
        sa = a[15];
        sb = b[15];
        if ((ea == 255 && a[6:0] != 0) || (eb == 255 && b[6:0] != 0)) return QNAN;
        if (ea == 255 && eb == 255) return (sa == sb) ? a : QNAN;
        if (ea == 255) return a;
        if (eb == 255) return b;
        ma = (ea == 0) ? 0 : longint'(128 + int'(a[6:0])) << G;
        mb = (eb == 0) ? 0 : longint'(128 + int'(b[6:0])) << G;
        if (ea >= eb) begin
            e = ea;
            d = ea - eb;
            if (d > MW) d = MW + 1;
`ifdef BFP16_ACC_RNE_EN
            sticky = (mb % (longint'(1) << d)) != 0;
`endif
            mb = mb >> d;
        end else begin
            e = eb;
            d = eb - ea;
            if (d > MW) d = MW + 1;
`ifdef BFP16_ACC_RNE_EN
            sticky = (ma % (longint'(1) << d)) != 0;
`endif
            ma = ma >> d;
        end
        if (sa == sb) begin
            mag  = ma + mb;
            sign = sa;
        end else if (ma >= mb) begin
            mag  = ma - mb;
            sign = sa;
        end else begin
            mag  = mb - ma;
            sign = sb;
        end
        if (mag == 0) return 16'h0000;
        top = longint'(1) << (MW - 1);
        if (mag >= 2 * top) begin
`ifdef BFP16_ACC_RNE_EN
            sticky = sticky || (mag % 2 != 0);
`endif
            mag = mag >> 1;
            e++;
        end
        while (mag < top) begin
            mag = mag << 1;
            e--;
        end
        if (e <= 0) return 16'h0000;
        frac = int'((mag >> G) % 128);
`ifdef BFP16_ACC_RNE_EN
        rem  = mag % (longint'(1) << G);
        half = longint'(1) << (G - 1);
        if (rem > half || (rem == half && (sticky || frac % 2 == 1))) begin
            frac++;
            if (frac == 128) begin
                frac = 0;
                e++;
            end
        end
`endif
        if (e >= 255) return {sign, 8'hFF, 7'h00};
        return {sign, 8'(e), 7'(frac)};
    endfunction

    function automatic logic [15:0] rand_elem();
        int         r;
        logic       s;
        logic [7:0] e;
        logic [6:0] f;
        r = $urandom_range(0, 99);
        s = 1'($urandom_range(0, 1));
        f = 7'($urandom_range(0, 127));
        if (r < 4)       e = 8'h00;
        else if (r < 7) begin
            e = 8'hFF;
            if ($urandom_range(0, 1) == 0) f = 7'h00;
            else                           f = f | 7'h01;
        end
        else if (r < 12) e = 8'($urandom_range(248, 254));
        else if (r < 18) e = 8'($urandom_range(1, 6));
        else             e = 8'($urandom_range(120, 136));
        return {s, e, f};
    endfunction

    // Sends stream_q, waits for the result, holds it for 'hold' cycles, then
    // accepts it. Called and returns on a falling edge.
    task automatic run_and_check(input string name, input logic [15:0] exp_data,
                                 input logic [CNT_W-1:0] exp_cnt, input int hold);
        int guard;
        int lat;
        for (int i = 0; i < stream_q.size(); i++) begin
            in_valid = 1'b1;
            in_data  = stream_q[i];
            in_last  = (i == stream_q.size() - 1);
            guard    = 0;
            while (!in_ready && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            checks++;
            if (guard >= 20) begin
                errors++;
                $display("FAIL %s in_ready_timeout: element %0d not accepted", name, i);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            checks++;
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy_phase: in_ready=%b busy=%b required 0/1", name, in_ready, busy);
            end
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL %s latency: out_valid after %0d cycles, required 3", name, lat);
            if (!out_valid) return;
        end
        checks++;
        if (out_data !== exp_data || out_count !== exp_cnt) begin
            errors++;
            $display("FAIL %s result: out_data=%h out_count=%0d required %h %0d",
                     name, out_data, out_count, exp_data, exp_cnt);
        end
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = 16'h7F80;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_data || out_count !== exp_cnt || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s hold%0d: valid=%b data=%h count=%0d in_ready=%b required 1 %h %0d 0",
                         name, h, out_valid, out_data, out_count, in_ready, exp_data, exp_cnt);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_data !== 16'h0000) begin
            errors++;
            $display("FAIL %s after_accept: valid=%b in_ready=%b busy=%b data=%h required 0 1 0 0000",
                     name, out_valid, in_ready, busy, out_data);
        end
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'h0000 ||
            out_count !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: in_ready=%b out_valid=%b out_data=%h out_count=%0d busy=%b required 1 0 0000 0 0",
                     name, in_ready, out_valid, out_data, out_count, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 16'h0000;
        in_last = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset_state");
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("idle_after_reset");
    endtask

    task automatic test_directed();
        stream_q = '{16'h3F80, 16'h4000};
        run_and_check("one_plus_two", 16'h4040, 4'd2, 0);
        stream_q = '{16'h3F80, 16'hBF80};
        run_and_check("cancellation", 16'h0000, 4'd2, 0);
        stream_q = '{16'h7F80, 16'hFF80};
        run_and_check("inf_minus_inf", QNAN, 4'd2, 0);
        stream_q = '{16'h7FC1, 16'h3F80};
        run_and_check("nan_sticky", QNAN, 4'd2, 0);
        stream_q = '{16'h3F80, 16'h3C40};
`ifdef BFP16_ACC_RNE_EN
        run_and_check("rounding", 16'h3F82, 4'd2, 0);
`else
        run_and_check("truncation", 16'h3F81, 4'd2, 0);
`endif
        stream_q = '{16'h0042};
        run_and_check("single_flush", 16'h0000, 4'd1, 0);
        stream_q = '{16'h7F00, 16'h7F00};
        run_and_check("overflow_inf", 16'h7F80, 4'd2, 0);
    endtask

    task automatic test_backpressure();
        stream_q = '{16'h3F80, 16'h4000};
        run_and_check("hold_five", 16'h4040, 4'd2, 5);
        stream_q = '{16'h4000};
        run_and_check("after_hold", 16'h4000, 4'd1, 0);
    endtask

    task automatic test_reset_mid_stream();
        in_valid = 1'b1;
        in_data  = 16'h3F80;
        in_last  = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_stream_busy: busy=%b required 1", busy);
        end
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("reset_in_norm");
        rst = 1'b0;
        stream_q = '{16'h3F80};
        run_and_check("after_abort", 16'h3F80, 4'd1, 0);
    endtask

    task automatic test_count_saturation();
        stream_q.delete();
        for (int i = 0; i < 17; i++) stream_q.push_back(16'h3F80);
        run_and_check("count_saturate", 16'h4188, 4'd15, 0);
    endtask

    task automatic test_random();
        logic [15:0] acc;
        int          n;
        for (int s = 0; s < 60; s++) begin
            n = $urandom_range(1, 6);
            stream_q.delete();
            acc = 16'h0000;
            for (int i = 0; i < n; i++) begin
                stream_q.push_back(rand_elem());
                acc = model_add(acc, stream_q[i]);
            end
            run_and_check($sformatf("random%0d", s), acc, CNT_W'(n), $urandom_range(0, 3));
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_stream();
        test_count_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
